uart_tx_sched: RTL

//  Shares one UART byte transmitter among NUM_REQ requesters (SDRAM read-back, status, debug).

---
 rtl/uart_sched_pkg.sv | 30 +++
 rtl/uart_rr_arb.sv | 78 +++++++
 rtl/uart_tx_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// ============================================================================
// Module  : uart_sched_pkg
// Brief   : Shared state encoding, defaults and width helpers for the UART TX scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

    localparam int unsigned DEF_BAUD_END = 5208;

    // Start bit + 8 data + stop bit, plus the transmitter's internal handshake slack.
    function automatic int unsigned frame_cycles(input int unsigned baud_end);
        return 10 * baud_end + 4;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_arb.sv
// ============================================================================
// Module  : uart_rr_arb
// Brief   : Winner search for the UART scheduler; round-robin by default,
//           fixed lowest-index priority when UART_SCHED_FIXED_PRIO_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_arb
    import uart_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               grant_en_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   win_o
);

`ifdef UART_SCHED_FIXED_PRIO_EN

    logic w_unused_ports;
    assign w_unused_ports = ^{clk_i, rst_i, grant_en_i};

    always_comb begin
        any_o = 1'b0;
        win_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                any_o = 1'b1;
                win_o = IDX_W'(k);
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Walk NUM_REQ candidates starting one past the last winner, wrapping at NUM_REQ.
    always_comb begin
        logic [IDX_W-1:0] cand;
        any_o = 1'b0;
        win_o = '0;
        cand  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                win_o = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en_i && any_o) begin
            ptr_d = win_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module  : uart_tx_sched
// Brief   : Shares one UART byte transmitter among NUM_REQ requesters and times
//           each frame itself. Option: UART_SCHED_FIXED_PRIO_EN (fixed priority).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BAUD_END  = DEF_BAUD_END,
    parameter int unsigned FRAME_CYC = frame_cycles(BAUD_END),
    parameter int unsigned GAP_CYC   = 0
) (
    input  logic                 sclk,
    input  logic                 s_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_flag,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int unsigned IDX_W      = idx_width(NUM_REQ);
    localparam logic [15:0] FRAME_LOAD = 16'(FRAME_CYC - 1);
    localparam logic [7:0]  GAP_LOAD   = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

    if (FRAME_CYC > 65535 || FRAME_CYC == 0) begin : g_frame_cyc_chk
        $error("uart_tx_sched: FRAME_CYC must be 1..65535");
    end

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYC > 255) begin : g_param_chk
        $error("uart_tx_sched: NUM_REQ must be 2..8 and GAP_CYC 0..255");
    end

    sched_state_e     state_q, state_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [2:0]       grant_q, grant_d;
    logic             arb_any;
    logic [IDX_W-1:0] arb_win;
    logic             grant_en;

    uart_rr_arb #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .clk_i      (sclk),
        .rst_i      (s_rst),
        .req_i      (req_valid),
        .grant_en_i (grant_en),
        .any_o      (arb_any),
        .win_o      (arb_win)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_data_d   = tx_data_q;
        grant_d     = grant_q;
        req_ready   = '0;
        tx_flag     = 1'b0;
        busy        = 1'b1;
        grant_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (arb_any) begin
                    grant_en           = 1'b1;
                    req_ready[arb_win] = 1'b1;
                    tx_data_d          = req_data[{arb_win, 3'b000} +: 8];
                    grant_d            = 3'(arb_win);
                    state_d            = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_flag     = 1'b1;
                frame_cnt_d = FRAME_LOAD;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_cnt_q == 16'd0) begin
                    if (GAP_CYC != 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            tx_data_q   <= 8'h00;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_data_q   <= tx_data_d;
            grant_q     <= grant_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;

endmodule

`default_nettype wire
